// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit_if
// Brief    : Request/result bundle between the issue logic and mul_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       rd_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       rd_out;
  logic             wr_out;
  logic             dz;

  modport master (
    output start, op, a, b, rd_in,
    input  busy, done, result, rd_out, wr_out, dz
  );

  modport slave (
    input  start, op, a, b, rd_in,
    output busy, done, result, rd_out, wr_out, dz
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative unsigned MUL/MULH/DIVU/REMU, one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [3:0]       r_rd;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_rd_out;
  logic             r_dz;

  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_result_nxt;

  assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:                   w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // hi/lo form one 2*WIDTH register: product {hi,lo} for multiply,
  // {remainder,quotient} for divide (lo starts as the dividend).
  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {WIDTH{1'b0}})};
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_b};
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (!r_op[1]) begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      // A zero divisor always subtracts, giving all-ones quotient and rem = a
      w_hi_nxt = w_diff[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
    end
    w_result_nxt = r_op[0] ? w_hi_nxt : w_lo_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_rd_out <= '0;
      r_dz     <= 1'b0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_op  <= bus.op;
      r_b   <= bus.b;
      r_rd  <= bus.rd_in;
      r_hi  <= '0;
      r_lo  <= bus.a;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_result_nxt;
        r_rd_out <= r_rd;
        r_dz     <= r_op[1] && (r_b == '0);
      end
    end
  end

  assign bus.busy   = (r_state == RUN);
  assign bus.done   = (r_state == DONE);
  assign bus.wr_out = (r_state == DONE);
  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;
  assign bus.dz     = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Scoreboard bench for mul_div_unit: model results queued at issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  rd;
    logic        dz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] last_res;

  mul_div_unit_if #(.WIDTH(16)) mif ();

  mul_div_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = {16'h0, x} * {16'h0, y};
    case (o)
      2'b00:   model = p[15:0];
      2'b01:   model = p[31:16];
      2'b10:   model = (y == 16'h0) ? 16'hFFFF : x / y;
      default: model = (y == 16'h0) ? x : x % y;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst && mif.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'(mif.result), 32'(mon_e.res));
        check("rd_out", 32'(mif.rd_out), 32'(mon_e.rd));
        check("dz", 32'(mif.dz), 32'(mon_e.dz));
        check("wr_out", 32'(mif.wr_out), 32'd1);
      end
    end
  end

  // Issue one operation; optionally re-pulse start with a=9 at RUN cycle inj.
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] rd, input int inj);
    exp_t e;
    int   nbusy;
    int   guard;
    e.res = model(o, x, y);
    e.rd  = rd;
    e.dz  = o[1] && (y == 16'h0);
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = o;
    mif.a     = x;
    mif.b     = y;
    mif.rd_in = rd;
    sb.push_back(e);
    @(negedge clk);
    mif.start = 1'b0;
    mif.a     = 16'($urandom);
    mif.b     = 16'($urandom);
    mif.rd_in = 4'($urandom);
    nbusy = 0;
    guard = 0;
    while (!mif.done && guard < 40) begin
      if (mif.busy) nbusy++;
      if (guard == 3) check("result_hold", 32'(mif.result), 32'(last_res));
      if (inj > 0 && guard == inj) begin
        mif.start = 1'b1;
        mif.a     = 16'h0009;
      end
      if (inj > 0 && guard == inj + 1) mif.start = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("done_timeout", 32'd0, 32'd1);
    check("busy_cycles", 32'(nbusy), 32'd16);
    check("busy_in_done", 32'(mif.busy), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(mif.done), 32'd0);
    check("wr_pulse", 32'(mif.wr_out), 32'd0);
    check("result_kept", 32'(mif.result), 32'(e.res));
    last_res = e.res;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_res  = 16'h0;
    mif.start = 1'b0;
    mif.op    = 2'b00;
    mif.a     = 16'h0;
    mif.b     = 16'h0;
    mif.rd_in = 4'h0;
    rst       = 1'b1;
    #1 rst    = 1'b0;
    #12;
    check("rst_busy", 32'(mif.busy), 32'd0);
    check("rst_done", 32'(mif.done), 32'd0);
    check("rst_wr", 32'(mif.wr_out), 32'd0);
    check("rst_dz", 32'(mif.dz), 32'd0);
    check("rst_result", 32'(mif.result), 32'd0);
    check("rst_rd", 32'(mif.rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(2'b00, 16'h0003, 16'h0005, 4'h4, 0);
    do_op(2'b01, 16'hFFFF, 16'hFFFF, 4'h1, 0);
    do_op(2'b00, 16'hFFFF, 16'hFFFF, 4'h2, 0);
    do_op(2'b10, 16'h0064, 16'h0007, 4'h3, 0);
    do_op(2'b11, 16'h0064, 16'h0007, 4'h5, 0);
    do_op(2'b10, 16'h1234, 16'h0000, 4'h6, 0);
    do_op(2'b11, 16'h1234, 16'h0000, 4'h7, 0);
    do_op(2'b10, 16'h0064, 16'h0007, 4'h8, 5);

    // Abandon an operation at RUN cycle 8
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = 2'b00;
    mif.a     = 16'h00AA;
    mif.b     = 16'h0011;
    mif.rd_in = 4'h9;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrun_busy", 32'(mif.busy), 32'd0);
    check("midrun_done", 32'(mif.done), 32'd0);
    check("midrun_result", 32'(mif.result), 32'd0);
    check("midrun_rd", 32'(mif.rd_out), 32'd0);
    @(negedge clk);
    rst      = 1'b1;
    last_res = 16'h0;
    repeat (20) @(negedge clk);
    do_op(2'b00, 16'h0002, 16'h0003, 4'hA, 0);

    for (int i = 0; i < 6; i++) begin
      do_op(2'($urandom), 16'($urandom), (i == 2) ? 16'h0001 : 16'($urandom), 4'($urandom), 0);
    end

    repeat (20) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width, matching the register file data width.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset (0 = reset).
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MUL (low half of product), 01 MULH (unsigned high half), 10 DIVU (quotient), 11 REMU (remainder).
REQ-006 The block SHALL have port a, input, WIDTH bits: first operand, driven from register file Rout1.
REQ-007 The block SHALL have port b, input, WIDTH bits: second operand, driven from register file Rout2.
REQ-008 The block SHALL have port rd_in, input, 4 bits: destination register index for the result.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is iterating.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse when the result is valid.
REQ-011 The block SHALL have port result, output, WIDTH bits: operation result, routed to register file RW.
REQ-012 The block SHALL have port rd_out, output, 4 bits: latched destination index, routed to register file Rd.
REQ-013 The block SHALL have port wr_out, output, 1 bit: register file write enable, identical to done.
REQ-014 The block SHALL have port dz, output, 1 bit: divide-by-zero flag, valid while done is high.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 at a rising edge, the block SHALL latch a, b, op and rd_in, clear the iteration counter, and enter RUN.
REQ-017 The block SHALL ignore start in RUN and DONE; latched operands SHALL NOT change until the next accepted start.
REQ-018 RUN SHALL last exactly WIDTH cycles, one iteration per cycle; a 4-bit counter SHALL count 0..15, and the edge at count 15 SHALL enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE; back-to-back operation therefore costs WIDTH+2 cycles.
REQ-020 busy SHALL equal 1 exactly in RUN.
REQ-021 done and wr_out SHALL equal 1 exactly in DONE, first visible WIDTH edges after the start-sampling edge.
REQ-022 MUL and MULH SHALL use an unsigned shift-add multiply into a 2*WIDTH accumulator; MUL SHALL return bits [15:0] and MULH bits [31:16].
REQ-023 DIVU and REMU SHALL use unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-024 When b=0 for DIVU/REMU, the block SHALL still take WIDTH cycles; quotient SHALL be 0xFFFF, remainder SHALL be a, and dz SHALL be 1 during DONE.
REQ-025 dz SHALL be 0 for MUL/MULH and for a nonzero divisor.
REQ-026 result, rd_out and dz SHALL update only on entry to DONE and hold until the next DONE.
REQ-027 Intermediate accumulator values SHALL NOT appear on result.

Reset
REQ-028 When rst=0, the block SHALL asynchronously force state IDLE, counter 0, busy=0, done=0, wr_out=0, dz=0, result=0x0000 and rd_out=0x0.
REQ-029 A reset asserted mid-RUN or in DONE SHALL abandon the operation with no wr_out pulse; the first start after rst returns to 1 SHALL behave normally.

Verification
REQ-030 MUL a=0x0003 b=0x0005 rd_in=0x4 -> busy for 16 cycles; one-cycle done/wr_out; result=0x000F; rd_out=0x4; dz=0.
REQ-031 MULH a=0xFFFF b=0xFFFF -> result=0xFFFE; the same operands with MUL -> result=0x0001.
REQ-032 DIVU a=0x0064 b=0x0007 -> result=0x000E; REMU with the same operands -> result=0x0002.
REQ-033 DIVU a=0x1234 b=0x0000 -> result=0xFFFF, dz=1; REMU with the same operands -> result=0x1234, dz=1.
REQ-034 start pulsed at RUN cycle 5 with a=0x0009 -> ignored; the original result completes on schedule; no extra done.
REQ-035 rst=0 at RUN cycle 8 -> busy=0 immediately, no done pulse, result=0x0000; the next MUL 0x0002*0x0003 -> result=0x0006.
